twiddle_rotator_64: RTL

TWIDDLE_ROTATOR_64 -- requirements
Module: twiddle_rotator_64

---
 rtl/twiddle_rotator_64.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/twiddle_rotator_64.sv
// Complex sample rotator: multiplies each input sample by a twiddle factor read from an
// external registered table indexed by the sample's position in its frame.
module twiddle_rotator_64 #(
  parameter int DIN_W = 10,
  parameter int TW_W  = 9,
  parameter int N     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_valid,
  input  logic                      din_sof,
  input  logic signed [DIN_W-1:0]   din_re,
  input  logic signed [DIN_W-1:0]   din_im,
  output logic [$clog2(N)-1:0]      tw_addr,
  input  logic signed [TW_W-1:0]    tw_re,
  input  logic signed [TW_W-1:0]    tw_im,
  output logic                      dout_valid,
  output logic                      dout_sof,
  output logic signed [DIN_W-1:0]   dout_re,
  output logic signed [DIN_W-1:0]   dout_im,
  output logic                      frame_err
);

  localparam int AW   = $clog2(N);
  localparam int PW   = DIN_W + TW_W;
  localparam int SW   = PW + 1;
  localparam int RW   = SW + 1;
  localparam int FRAC = TW_W - 2;
  localparam logic signed [RW-1:0] SMAX = RW'((1 <<< (DIN_W - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = RW'(-(1 <<< (DIN_W - 1)));

  // Round half up (floor of x+0.5) on the Q1.7 product sum, then clamp to the output range.
  function automatic logic signed [DIN_W-1:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [RW-1:0] t;
    t = (RW'(s) + RW'(1 <<< (FRAC - 1))) >>> FRAC;
    if (t > SMAX) t = SMAX;
    else if (t < SMIN) t = SMIN;
    return t[DIN_W-1:0];
  endfunction

  logic          acc;
  logic [AW-1:0] idx_q, idx_d, idx_cur, addr_q;

  logic                     vld_p1_q, sof_p1_q, err_p1_q;
  logic signed [DIN_W-1:0]  re_p1_q, im_p1_q;
  logic                     vld_p2_q, sof_p2_q, err_p2_q;
  logic signed [PW-1:0]     rr_p2_q, ii_p2_q, ri_p2_q, ir_p2_q;
  logic signed [SW-1:0]     re_sum, im_sum;
  logic                     dout_valid_q, dout_sof_q, frame_err_q;
  logic signed [DIN_W-1:0]  dout_re_q, dout_im_q;

  // Stage p0: index assignment and twiddle address for the sample on the inputs.
  assign acc     = din_valid & ~rst;
  assign idx_cur = din_sof ? '0 : idx_q;

  always_comb begin
    idx_d = idx_q;
    if (acc) idx_d = (idx_cur == AW'(N - 1)) ? '0 : idx_cur + AW'(1);
  end

  always_comb begin
    tw_addr = addr_q;
    if (rst) tw_addr = '0;
    else if (din_valid) tw_addr = idx_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= tw_addr;
    end
  end

  // Stage p1: sample registered, aligned with the table output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      sof_p1_q <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= acc;
      sof_p1_q <= acc & (idx_cur == '0);
      err_p1_q <= acc & din_sof & (idx_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      re_p1_q <= din_re;
      im_p1_q <= din_im;
    end
  end

  // Stage p2: the four partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      sof_p2_q <= 1'b0;
      err_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      sof_p2_q <= sof_p1_q;
      err_p2_q <= err_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    rr_p2_q <= PW'(re_p1_q) * PW'(tw_re);
    ii_p2_q <= PW'(im_p1_q) * PW'(tw_im);
    ri_p2_q <= PW'(re_p1_q) * PW'(tw_im);
    ir_p2_q <= PW'(im_p1_q) * PW'(tw_re);
  end

  // Stage p3: full-precision sums, rounding, saturation; data holds across bubbles.
  assign re_sum = SW'(rr_p2_q) - SW'(ii_p2_q);
  assign im_sum = SW'(ri_p2_q) + SW'(ir_p2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
    end else begin
      dout_valid_q <= vld_p2_q;
      dout_sof_q   <= vld_p2_q & sof_p2_q;
      frame_err_q  <= vld_p2_q & err_p2_q;
      if (vld_p2_q) begin
        dout_re_q <= round_sat(re_sum);
        dout_im_q <= round_sat(im_sum);
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign frame_err  = frame_err_q;
  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;

endmodule
